// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle LSB first, result valid WIDTH cycles after start, held until ack.
// Optional subtraction mode (in_sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_operand1,
  input  logic [WIDTH-1:0] in_operand2,
  input  logic             in_carry,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_sum_ack,
  output logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, sum, sum_shift, b_load;
  logic             c, c_load, s_bit, c_nxt, last_bit;
  logic [CW-1:0]    cnt;

  always_comb begin
    b_load = in_operand2;
    c_load = in_carry;
`ifdef SERIAL_ADDER_SUB_EN
    if (in_sub) begin
      b_load = ~in_operand2;
      c_load = 1'b1;
    end
`endif
  end

  assign s_bit    = a[0] ^ b[0] ^ c;
  assign c_nxt    = (a[0] & b[0]) | ((a[0] ^ b[0]) & c);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The new sum bit enters at the MSB; a 1-bit sum register is just the bit itself.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = s_bit;
    end else begin : g_wn
      assign sum_shift = {s_bit, sum[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (in_sum_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_start) begin
          a   <= in_operand1;
          b   <= b_load;
          c   <= c_load;
          cnt <= '0;
        end
        RUN: begin
          a   <= a >> 1;
          b   <= b >> 1;
          c   <= c_nxt;
          sum <= sum_shift;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum;
  assign out_carry = c;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised + directed bench for serial_adder (WIDTH=8 against an arithmetic model, WIDTH=1 directed).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst, start, cin, ack, sub;
  logic [7:0] op1, op2;
  logic       ready, valid, cout;
  logic [7:0] sum;

  logic       start1, ack1;
  logic       ready1, valid1, cout1;
  logic [0:0] op1_1, op2_1, sum1;
  logic       cin1;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .in_clk(clk), .in_rst(rst), .in_start(start),
    .in_operand1(op1), .in_operand2(op2), .in_carry(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub(sub),
`endif
    .in_sum_ack(ack), .out_ready(ready), .out_valid(valid),
    .out_sum(sum), .out_carry(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_start(start1),
    .in_operand1(op1_1), .in_operand2(op2_1), .in_carry(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub(1'b0),
`endif
    .in_sum_ack(ack1), .out_ready(ready1), .out_valid(valid1),
    .out_sum(sum1), .out_carry(cout1)
  );

  // Transaction-level model: result is plain arithmetic, latency is a countdown.
  int         m_left = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_sum  = '0;
  logic       m_carry = 1'b0;
  logic [8:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_sum = '0; m_carry = 1'b0;
    end else if (m_done) begin
      if (ack) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done  = 1'b1;
        m_sum   = m_pend[7:0];
        m_carry = m_pend[8];
      end
    end else if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) m_pend = {1'b0, op1} + {1'b0, ~op2} + 9'd1;
      else     m_pend = {1'b0, op1} + {1'b0, op2} + {8'd0, cin};
`else
      m_pend = {1'b0, op1} + {1'b0, op2} + {8'd0, cin};
`endif
      m_left = 8;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("ready", 64'(ready), 64'(m_left == 0 && !m_done));
      check("valid", 64'(valid), 64'(m_done));
      if (m_left == 0) begin
        check("sum", 64'(sum), 64'(m_sum));
        check("carry", 64'(cout), 64'(m_carry));
      end
    end
  end

  // One operation; sample at #1 after edges. pulse pokes in_start during RUN and DONE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                       input int hold, input bit pulse, input bit lit,
                       input logic [7:0] exp_s, input logic exp_c);
    int n;
    @(posedge clk); #1;
    op1 = a; op2 = b; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!valid && n < 50) begin
      start = pulse && (n == 2);
      ack   = 1'($urandom_range(0, 1));
      op1   = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; ack = 1'b0;
    check("latency", 64'(n), 64'd8);
    if (lit) begin
      check("lit_sum", 64'(sum), 64'(exp_s));
      check("lit_carry", 64'(cout), 64'(exp_c));
    end
    for (int i = 0; i < hold; i++) begin
      start = pulse;
      @(posedge clk); #1;
      check("hold_valid", 64'(valid), 64'd1);
      if (lit) check("hold_sum", 64'(sum), 64'(exp_s));
    end
    start = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("ack_ready", 64'(ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cin = 1'b0; ack = 1'b0; sub = 1'b0; op1 = '0; op2 = '0;
    start1 = 1'b0; ack1 = 1'b0; op1_1 = '0; op2_1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry", 64'(cout), 64'd0);
    chk_on = 1'b1;

    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'h7F, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h00, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'hFF, 1'b1);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0, 5, 1'b1, 1'b1, 8'h00, 1'b1);
    // idle retains previous result across several cycles
    repeat (3) @(posedge clk);
    #1 check("idle_retain", 64'(sum), 64'h00);

    // reset during the 4th RUN cycle
    @(posedge clk); #1;
    op1 = 8'h77; op2 = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'h0F, 1'b1);
    do_op(8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'hFF, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // WIDTH=1: 1+1+1 -> sum 1, carry 1, valid one cycle after accept
    @(posedge clk); #1;
    op1_1 = 1'b1; op2_1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("w1_run_valid", 64'(valid1), 64'd0);
    @(posedge clk); #1;
    check("w1_valid", 64'(valid1), 64'd1);
    check("w1_sum", 64'(sum1), 64'd1);
    check("w1_carry", 64'(cout1), 64'd1);
    ack1 = 1'b1;
    @(posedge clk); #1;
    ack1 = 1'b0;
    check("w1_ready", 64'(ready1), 64'd1);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/sum width in bits (legal range 1..64).
REQ-002 SHALL have clocking: one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: in_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port: in_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port: in_start  input  1  request to begin an addition, sampled only in IDLE.
REQ-006 SHALL have port: in_operand1  input  WIDTH  first addend, captured on accepted start.
REQ-007 SHALL have port: in_operand2  input  WIDTH  second addend, captured on accepted start.
REQ-008 SHALL have port: in_carry  input  1  carry-in, captured on accepted start.
REQ-009 SHALL have port: in_sum_ack  input  1  consumer acknowledge of the result, sampled only in DONE.
REQ-010 SHALL have port: out_ready  output  1  high exactly when the state is IDLE.
REQ-011 SHALL have port: out_valid  output  1  high exactly when the state is DONE.
REQ-012 SHALL have port: out_sum  output  WIDTH  result, (operand1+operand2+carry) mod 2^WIDTH.
REQ-013 SHALL have port: out_carry  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement a three-state machine: IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with in_start=1, load operand shift registers A and B and carry register C, clear the bit counter, and enter RUN.
REQ-016 SHALL, in each RUN cycle, compute s=A[0]^B[0]^C and C<=A[0]&B[0] | (A[0]^B[0])&C, shift A and B right by one, shift s into the sum register MSB (sum shifts right), and increment the counter.
REQ-017 SHALL process bits LSB first, one bit per cycle; after the bit with counter==WIDTH-1 it SHALL enter DONE.
REQ-018 SHALL assert out_valid exactly WIDTH cycles after the edge that accepts in_start.
REQ-019 SHALL hold out_sum and out_carry stable for the whole of DONE; both are meaningful only while out_valid=1.
REQ-020 SHALL, in DONE with in_sum_ack=1, enter IDLE on the next edge; DONE SHALL persist indefinitely while in_sum_ack=0.
REQ-021 SHALL ignore in_start in RUN and DONE; the earliest next acceptance is the cycle after the ack edge.
REQ-022 SHALL ignore in_sum_ack outside DONE.
REQ-023 SHALL, in IDLE, retain the last out_sum/out_carry until the next accepted start.
REQ-024 SHALL size the bit counter to hold WIDTH-1 without wrap; the counter SHALL clear on every accepted start.

Reset
REQ-025 SHALL, on in_rst=1 at a rising edge, force IDLE and clear A, B, C, counter, out_sum and out_carry to 0, from any state including mid-RUN.
REQ-026 SHALL give in_rst priority over simultaneous in_start or in_sum_ack.
REQ-027 SHALL present out_ready=1, out_valid=0, out_sum=0 and out_carry=0 after reset.

Configuration
REQ-028 SHALL, when SERIAL_ADDER_SUB_EN is defined, add the port in_sub  input  1, captured on accepted start; with in_sub=1, B SHALL load ~in_operand2 and C SHALL load 1 (in_carry ignored), giving operand1-operand2 mod 2^WIDTH, where out_carry=1 means no borrow.
REQ-029 SHALL, when SERIAL_ADDER_SUB_EN is undefined, omit the in_sub port and perform addition only.

Verification
REQ-030 SHALL cover, with WIDTH=8: 0x35+0x4A, cin=0 -> out_valid 8 cycles after the accept edge, out_sum=0x7F, out_carry=0.
REQ-031 SHALL cover carry wrap: 0xFF+0x01, cin=0 -> 0x00, carry=1; and 0xFF+0xFF, cin=1 -> 0xFF, carry=1.
REQ-032 SHALL cover the hold and ignore rules: hold in_sum_ack=0 for 5 cycles in DONE, pulse in_start in RUN and in DONE -> result stable and starts ignored; on ack, out_ready=1 on the next cycle.
REQ-033 SHALL cover reset mid-run: in_rst at the 4th RUN cycle -> next cycle IDLE, out_valid=0, out_sum=0; a following 0x01+0x01 yields 0x02.
REQ-034 SHALL cover subtraction with SUB_EN: 0x10-0x01 -> 0x0F, carry=1; 0x01-0x02 -> 0xFF, carry=0.
REQ-035 SHALL cover the minimum width, WIDTH=1: 1+1, cin=1 -> out_valid 1 cycle after accept, out_sum=1, out_carry=1.
